// File: rtl/decode_queue.sv
// Fetch-to-decode circular queue presenting its head entry pre-decoded (RV32I fields + immediate).
// Optional DECODE_ILLEGAL_CHK_EN adds the IllegalD output flagging unsupported opcodes.
module decode_queue #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instrF,
  input  logic [XLEN-1:0]  PCF,
  input  logic             validF,
  output logic             readyF,
  input  logic             FlushD,
  input  logic             readyD,
  output logic             validD,
  output logic [31:0]      instrD,
  output logic [XLEN-1:0]  PCD,
  output logic [4:0]       Rs1D,
  output logic [4:0]       Rs2D,
  output logic [4:0]       RdD,
  output logic [6:0]       OP,
  output logic [2:0]       funct3,
  output logic [6:0]       funct77,
  output logic             funct7,
  output logic [XLEN-1:0]  ImmExtD,
  output logic [PTR_W:0]   count
`ifdef DECODE_ILLEGAL_CHK_EN
  ,
  output logic             IllegalD
`endif
);

  localparam logic [31:0]    NOP  = 32'h0000_0013;
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;
  logic [31:0]      imm32;

  assign readyF = (count_q != FULL);
  assign validD = (count_q != '0);
  assign count  = count_q;

  // A redirect suppresses both handshakes so the dropped instruction never lands.
  assign push = validF && readyF && !FlushD;
  assign pop  = validD && readyD && !FlushD;

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FlushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately left unreset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= instrF;
      pc_q[wr_ptr_q]    <= PCF;
    end
  end

  assign instrD  = validD ? instr_q[rd_ptr_q] : NOP;
  assign PCD     = validD ? pc_q[rd_ptr_q]    : '0;
  assign Rs1D    = instrD[19:15];
  assign Rs2D    = instrD[24:20];
  assign RdD     = instrD[11:7];
  assign OP      = instrD[6:0];
  assign funct3  = instrD[14:12];
  assign funct77 = instrD[31:25];
  assign funct7  = instrD[30];

  always_comb begin
    imm32 = '0;
    case (OP)
      7'b0010011, 7'b0000011, 7'b1100111:
        imm32 = {{20{instrD[31]}}, instrD[31:20]};
      7'b0100011:
        imm32 = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      7'b1100011:
        imm32 = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {instrD[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign ImmExtD = XLEN'($signed(imm32));

`ifdef DECODE_ILLEGAL_CHK_EN
  logic op_known;
  always_comb begin
    op_known = OP inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                          7'b1110011};
  end
  assign IllegalD = validD && ((instrD[1:0] != 2'b11) || !op_known);
`endif

endmodule
